// File: rtl/nn_pkg.sv
// Shared constants, FSM state encoding and score type for the
// output-layer argmax controller and its compare stage.
package nn_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int DATA_W      = 16;
  localparam int IDX_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  typedef logic signed [DATA_W-1:0] score_t;

endpackage

// File: rtl/argmax_cmp_stage.sv
// Registered running-maximum tracker: on each enabled beat compares the
// incoming signed score against the held maximum and keeps value/index.
// The first beat of a sequence loads unconditionally; ties keep the
// earlier (lower) index because only a strictly greater score updates.
module argmax_cmp_stage
  import nn_pkg::*;
#(
  parameter int DATA_W = nn_pkg::DATA_W,
  parameter int IDX_W  = nn_pkg::IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              first,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] data,
  output logic [IDX_W-1:0]  max_index,
  output logic [DATA_W-1:0] max_value
);

  logic [IDX_W-1:0]  r_max_index;
  logic [DATA_W-1:0] r_max_value;
  logic              w_take;

  assign w_take = first || ($signed(data) > $signed(r_max_value));

  // Update the held maximum when a beat is accepted and wins the compare
  always_ff @(posedge clk) begin
    if (rst) begin
      r_max_index <= '0;
      r_max_value <= '0;
    end else if (en && w_take) begin
      r_max_index <= idx;
      r_max_value <= data;
    end
  end

  assign max_index = r_max_index;
  assign max_value = r_max_value;

endmodule

// File: rtl/argmax_seq_ctrl.sv
// Sequential argmax controller: collects NUM_CLASSES serial signed scores,
// tracks the winner one compare per cycle, then presents index, value and
// the captured score vector under a valid/ready result handshake.
module argmax_seq_ctrl
  import nn_pkg::*;
#(
  parameter int NUM_CLASSES = nn_pkg::NUM_CLASSES,
  parameter int DATA_W      = nn_pkg::DATA_W,
  parameter int IDX_W       = nn_pkg::IDX_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          in_ready,
  output logic                          busy,
  output logic                          result_valid,
  input  logic                          result_ready,
  output logic [IDX_W-1:0]              max_index,
  output logic [DATA_W-1:0]             max_value,
  output logic [NUM_CLASSES*DATA_W-1:0] scores_packed
);

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_last;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == IDX_W'(NUM_CLASSES - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic; start is only honoured in IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (start)             w_state_next = ST_LOAD;
      ST_LOAD:   if (w_accept && w_last) w_state_next = ST_RESULT;
      ST_RESULT: if (result_ready)      w_state_next = ST_IDLE;
      default:                          w_state_next = ST_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state
  always_comb begin
    in_ready     = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    case (r_state)
      ST_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      ST_RESULT: begin
        busy         = 1'b1;
        result_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Beat counter: cleared on start, advanced per beat, held on the final
  // beat so it never wraps even when NUM_CLASSES == 2**IDX_W
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_cnt <= '0;
    end else if (w_accept && !w_last) begin
      r_cnt <= r_cnt + IDX_W'(1);
    end
  end

  // Score buffer: one register per class, class 0 in the top bits
  generate
    for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_slot
      logic [DATA_W-1:0] r_slot;

      // Capture the beat addressed to this slot
      always_ff @(posedge clk) begin
        if (rst)                                      r_slot <= '0;
        else if (w_accept && (r_cnt == IDX_W'(gi)))   r_slot <= in_data;
      end

      assign scores_packed[(NUM_CLASSES-gi)*DATA_W-1 -: DATA_W] = r_slot;
    end
  endgenerate

  argmax_cmp_stage #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_cmp (
    .clk       (clk),
    .rst       (rst),
    .en        (w_accept),
    .first     (r_cnt == '0),
    .idx       (r_cnt),
    .data      (in_data),
    .max_index (max_index),
    .max_value (max_value)
  );

endmodule

// File: tb/tb_argmax_seq_ctrl.sv
// Directed bench for argmax_seq_ctrl: a table of inferences with
// hand-computed winners plus hand-written reset sequences.
module tb_argmax_seq_ctrl;
  import nn_pkg::*;

  localparam int NC = NUM_CLASSES;
  localparam int DW = DATA_W;
  localparam int IW = IDX_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [DW-1:0]     in_data;
  logic              in_ready;
  logic              busy;
  logic              result_valid;
  logic              result_ready;
  logic [IW-1:0]     max_index;
  logic [DW-1:0]     max_value;
  logic [NC*DW-1:0]  scores_packed;

  always #5 clk = ~clk;

  argmax_seq_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .busy          (busy),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .max_index     (max_index),
    .max_value     (max_value),
    .scores_packed (scores_packed)
  );

  typedef struct packed {
    logic [0:NC-1][DW-1:0] scores;
    int                    gap;
    int                    hold;
    logic                  start_noise;
    logic                  valid_with_start;
    logic [IW-1:0]         exp_idx;
    logic [DW-1:0]         exp_val;
  } vec_t;

  vec_t  tbl [5];
  int    total = 0;
  int    bad   = 0;
  string cur_tag;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [NC*DW-1:0] act,
                       input logic [NC*DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s/%s: got %0h expected %0h", cur_tag, name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input string tag);
    logic [NC*DW-1:0] exp_pk;
    cur_tag = tag;
    exp_pk  = '0;
    for (int k = 0; k < NC; k++) exp_pk[(NC-k)*DW-1 -: DW] = v.scores[k];

    start = 1'b1;
    if (v.valid_with_start) begin
      in_valid = 1'b1;
      in_data  = 16'h0777;
    end
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    check("ready_load", in_ready, 1);
    check("busy_load", busy, 1);

    for (int k = 0; k < NC; k++) begin
      in_valid = 1'b1;
      in_data  = v.scores[k];
      if (v.start_noise) start = 1'b1;
      if (k == NC - 1) check("rv_before_last", result_valid, 0);
      tick();
      in_valid = 1'b0;
      start    = 1'b0;
      if (k < NC - 1) begin
        for (int g = 0; g < v.gap; g++) begin
          check("ready_gap", in_ready, 1);
          tick();
        end
      end
    end

    check("rv_after_last", result_valid, 1);
    check("ready_result", in_ready, 0);
    check("busy_result", busy, 1);
    check("max_index", max_index, v.exp_idx);
    check("max_value", max_value, v.exp_val);
    check("packed", scores_packed, exp_pk);

    for (int h = 0; h < v.hold; h++) begin
      start        = v.start_noise;
      result_ready = 1'b0;
      tick();
      check("rv_hold", result_valid, 1);
      check("idx_hold", max_index, v.exp_idx);
      check("val_hold", max_value, v.exp_val);
    end

    result_ready = 1'b1;
    start        = 1'b0;
    tick();
    result_ready = 1'b0;
    check("rv_done", result_valid, 0);
    check("busy_idle", busy, 0);
    check("ready_idle", in_ready, 0);
    check("idx_keep", max_index, v.exp_idx);
    check("val_keep", max_value, v.exp_val);
    check("packed_keep", scores_packed, exp_pk);
    tick();
    check("busy_not_queued", busy, 0);
    $display("inference %s: max_index=%0d max_value=%0h gap=%0d hold=%0d",
             tag, max_index, max_value, v.gap, v.hold);
  endtask

  initial begin
    tbl[0] = '{scores: {16'sd5, -16'sd3, 16'sd12, 16'sd7, 16'sd0,
                        16'sd1, 16'sd2, 16'sd3, 16'sd4, -16'sd8},
               gap: 0, hold: 0, start_noise: 1'b0, valid_with_start: 1'b0,
               exp_idx: 4'd2, exp_val: 16'd12};
    tbl[1] = '{scores: {-16'sd100, -16'sd7, -16'sd7, -16'sd50, -16'sd9,
                        -16'sd20, -16'sd30, -16'sd40, -16'sd60, -16'sd70},
               gap: 2, hold: 0, start_noise: 1'b0, valid_with_start: 1'b0,
               exp_idx: 4'd1, exp_val: 16'hFFF9};
    tbl[2] = '{scores: {16'sd0, 16'sd1, 16'sd2, 16'sd3, 16'sd4,
                        16'sd5, 16'sd6, 16'sd7, 16'sd8, 16'sh7FFF},
               gap: 0, hold: 5, start_noise: 1'b0, valid_with_start: 1'b0,
               exp_idx: 4'd9, exp_val: 16'h7FFF};
    tbl[3] = '{scores: {16'sd3, 16'sd3, 16'sd3, 16'sd9, 16'sd9,
                        16'sd1, -16'sd2, 16'sd0, 16'sd9, 16'sd4},
               gap: 1, hold: 2, start_noise: 1'b1, valid_with_start: 1'b1,
               exp_idx: 4'd3, exp_val: 16'd9};
    tbl[4] = '{scores: {NC{16'h8000}},
               gap: 0, hold: 1, start_noise: 1'b0, valid_with_start: 1'b0,
               exp_idx: 4'd0, exp_val: 16'h8000};

    rst          = 1'b1;
    start        = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    result_ready = 1'b0;
    cur_tag      = "reset";
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("ready", in_ready, 0);
    check("busy", busy, 0);
    check("rv", result_valid, 0);
    check("idx", max_index, 0);
    check("val", max_value, 0);
    check("packed", scores_packed, 0);
    $display("reset: outputs idle");

    for (int i = 0; i < 4; i++) run(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of LOAD discards the partial inference
    cur_tag = "mid_reset";
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = DW'(100 * (k + 1));
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ready", in_ready, 0);
    check("busy", busy, 0);
    check("rv", result_valid, 0);
    check("idx", max_index, 0);
    check("val", max_value, 0);
    check("packed", scores_packed, 0);
    $display("mid_reset: partial inference discarded");
    tick();

    run(tbl[4], "vec4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
